// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider with kill and
// divide-by-zero flag (DIV/DIVU/REM/REMU, SIZE=33 on sign/zero-ext ops).
// Ports: clk, rst (async high), start/kill/is_signed, dividend/divisor in;
// ready, valid (1-cycle pulse), error, quotient, remainder out.
// SEQ_DIVIDER_EARLY_OUT_EN: skip CALC when |dividend| < |divisor|.
module seq_divider #(
  parameter int SIZE = 33
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic            is_signed,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            ready,
  output logic            valid,
  output logic            error,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] rem_q, rem_d;
  logic [SIZE-1:0] quo_q, quo_d;
  logic [SIZE-1:0] dvs_q, dvs_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [SIZE-1:0] quotient_q, quotient_d;
  logic [SIZE-1:0] remainder_q, remainder_d;
  logic            error_q, error_d;

  logic            a_neg;
  logic            b_neg;
  logic [SIZE-1:0] a_mag;
  logic [SIZE-1:0] b_mag;
  logic            b_zero;
  logic [SIZE:0]   rem_sh;
  logic            ge;
  logic [SIZE-1:0] sub;
  logic [SIZE-1:0] q_fix;
  logic [SIZE-1:0] r_fix;

  assign a_neg  = is_signed & dividend[SIZE-1];
  assign b_neg  = is_signed & divisor[SIZE-1];
  assign a_mag  = a_neg ? -dividend : dividend;
  assign b_mag  = b_neg ? -divisor : divisor;
  assign b_zero = (divisor == '0);

  // Shifted partial remainder needs one extra bit; the true difference
  // is always below the divisor, so the wrapped SIZE-bit sub is exact.
  assign rem_sh = {rem_q, quo_q[SIZE-1]};
  assign ge     = (rem_sh >= {1'b0, dvs_q});
  assign sub    = rem_sh[SIZE-1:0] - dvs_q;

  assign q_fix  = q_neg_q ? -quo_q : quo_q;
  assign r_fix  = r_neg_q ? -rem_q : rem_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    error_d     = error_q;
    unique case (state_q)
      IDLE: begin
        if (!kill && start) begin
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          dvs_d   = b_mag;
          rem_d   = '0;
          quo_d   = a_mag;
          if (b_zero) begin
            quotient_d  = '1;
            remainder_d = dividend;
            error_d     = 1'b1;
            state_d     = DONE;
          end
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
          else if (a_mag < b_mag) begin
            quo_d   = '0;
            rem_d   = a_mag;
            state_d = FIX;
          end
`endif
          else begin
            cnt_d   = CW'(SIZE);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          rem_d = ge ? sub : rem_sh[SIZE-1:0];
          quo_d = {quo_q[SIZE-2:0], ge};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          quotient_d  = q_fix;
          remainder_d = r_fix;
          error_d     = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      error_q     <= error_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign valid     = (state_q == DONE);
  assign error     = error_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring divider.
- Responder side of the execute stage's start/ready/valid divide handshake: the execute stage drives start and operands, then stalls until valid.
- Adds reset and a kill input so a pipeline flush can abort an in-flight divide.
- Used for DIV/DIVU/REM/REMU with SIZE=33 (sign- or zero-extended 32-bit operands).

Parameters:
- SIZE, 33, operand/result width in bits; counter width is clog2(SIZE+1).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  request; accepted only when ready=1
- kill  input  1  abort in-flight operation (pipeline flush)
- is_signed  input  1  operands/results are two's complement
- dividend  input  SIZE  dividend, sampled on accept
- divisor  input  SIZE  divisor, sampled on accept
- ready  output  1  block idle, can accept start
- valid  output  1  one-cycle pulse: quotient/remainder/error valid
- error  output  1  divide-by-zero flag, qualified by valid, held with results
- quotient  output  SIZE  result quotient, registered
- remainder  output  SIZE  result remainder, registered

Behaviour:
- Reset (async, any state): state=IDLE; ready=1; valid=0; error=0; quotient=0; remainder=0; counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: ready=1.
  - start=1 and kill=0 -> latch |dividend|, |divisor| (magnitudes only when is_signed), result signs (q_neg = sign(dividend) xor sign(divisor), r_neg = sign(dividend)) and divisor==0.
  - divisor==0 -> DONE directly.
  - Otherwise -> CALC with counter=SIZE.
- CALC: ready=0.
  - Each cycle: shift {rem, quo} left by 1, trial-subtract magnitude divisor from rem; if non-negative, keep the difference and set quo LSB.
  - Counter decrements; at counter==1 the next state is FIX.
- FIX: apply signs: quotient = q_neg ? -quo : quo; remainder = r_neg ? -rem : rem (SIZE-bit wrap). Next state DONE.
- DONE: valid=1 for exactly this cycle, ready=0. Next state IDLE.
- Outputs quotient/remainder/error hold their values from DONE until the next accepted start.
- Latency: start accepted at cycle 0 -> valid at cycle SIZE+2 (cycle 35 for SIZE=33). Divide-by-zero: valid at cycle 1.
- Divide-by-zero: quotient = all ones; remainder = dividend unmodified; error=1. Sign handling is skipped.
- Overflow (is_signed, dividend = most negative, divisor = -1): quotient = dividend, remainder = 0, error=0. This falls out of SIZE-bit wrap arithmetic; no special path.
- Unsigned mode: no magnitude or sign processing.
- kill:
  - Any state other than IDLE -> IDLE next cycle. No valid pulse; result registers unchanged.
  - In IDLE, kill takes priority over start, so the start is not accepted.
- start while ready=0 is ignored.
- Operand inputs are don't-care after accept.

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_OUT_EN.
- Defined: in IDLE, if the accepted divisor is nonzero and |dividend| < |divisor| (unsigned compare of magnitudes), skip CALC and go to FIX with quo=0, rem=|dividend|. valid arrives at cycle 2. Results are identical to the full path.
- Undefined: all nonzero-divisor operations take the full SIZE+2 cycles. The magnitude comparator is not synthesised.

Test Plan:
- Unsigned, SIZE=33: 100 / 7 -> valid at cycle 35; quotient=14, remainder=2, error=0. ready is low during cycles 1..35 and high at 36.
- Signed: -7 / 2 -> quotient=-3 (0x1_FFFF_FFFD), remainder=-1. Signed 7 / -2 -> quotient=-3, remainder=1.
- Divide-by-zero, signed: 0x1234 / 0 -> valid at cycle 1, quotient=all ones, remainder=0x1234, error=1.
- SIZE=8 signed overflow: -128 / -1 -> quotient=0x80, remainder=0, error=0.
- kill asserted at cycle 10 of a 100/7 divide -> IDLE and ready=1 at cycle 11, no valid pulse, previous results still present. A new start at cycle 11 completes normally.
- rst asserted asynchronously mid-CALC -> ready=1 and all outputs 0 immediately. With SEQ_DIVIDER_EARLY_OUT_EN defined, 3 / 10 -> valid at cycle 2, quotient=0, remainder=3.
